// File: rtl/buffer_addr_pkg.sv
// Shared types and derived-width helpers for the banked buffer write-address generator.
// Pure declarations: no logic, no latency, no flow control.
package buffer_addr_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL      = 2'd1,
      WAIT_BANK = 2'd2
   } wr_state_t;

   function automatic int calc_bank_aw(input int addr_w, input int num_banks);
      return addr_w - $clog2(num_banks);
   endfunction

   function automatic int calc_bank_idx_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

endpackage

// File: rtl/buffer_bank_status.sv
// Per-bank full flags (owned by the reader) with a free check that sees same-cycle set/clear.
// Flags update one cycle after set/clear; query_free is combinational. No backpressure.
module buffer_bank_status
   import buffer_addr_pkg::*;
#(
   parameter int NUM_BANKS = 2,
   parameter int IDX_W     = calc_bank_idx_w(NUM_BANKS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear_all,
   input  logic                 set_en,
   input  logic [IDX_W-1:0]     set_idx,
   input  logic                 clr_en,
   input  logic [IDX_W-1:0]     clr_idx,
   input  logic [IDX_W-1:0]     query_idx,
   output logic [NUM_BANKS-1:0] bank_full,
   output logic                 query_free
);

   logic q_full;
   logic q_set;
   logic q_clr;

   always_comb begin
      q_full = 1'b0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (IDX_W'(i) == query_idx) begin
            q_full = bank_full[i];
         end
      end
   end

   assign q_set = set_en && (set_idx == query_idx);
   assign q_clr = clr_en && (clr_idx == query_idx);

   // A release only helps if the bank is already full; a bank being filled right now is busy.
   assign query_free = !(q_full || q_set) || (q_clr && q_full);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_full <= '0;
      end else if (clear_all) begin
         bank_full <= '0;
      end else begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (set_en && (set_idx == IDX_W'(i))) begin
               bank_full[i] <= 1'b1;
            end else if (clr_en && (clr_idx == IDX_W'(i))) begin
               bank_full[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/buffer_write_bank_addr_gen.sv
// Banked write-address generator: fills NUM_BANKS banks in rotation, one write per cycle.
// Address/status registered (1 cycle); ready_o drops while the next bank is still owned by the reader.
module buffer_write_bank_addr_gen
   import buffer_addr_pkg::*;
#(
   parameter  int BUFFER_ADDRESS_WIDTH = 10,
   parameter  int NUM_BANKS            = 2,
   parameter  int COUNT_WIDTH          = 16,
   localparam int BANK_AW              = calc_bank_aw(BUFFER_ADDRESS_WIDTH, NUM_BANKS),
   localparam int BANK_DEPTH           = 2 ** BANK_AW,
   localparam int BANK_IDX_W           = calc_bank_idx_w(NUM_BANKS)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start_i,
   input  logic [BANK_AW:0]                fill_len_i,
   input  logic                            count_up,
   input  logic                            release_i,
   input  logic [BANK_IDX_W-1:0]           release_bank_i,
   output logic [BUFFER_ADDRESS_WIDTH-1:0] address,
   output logic                            ready_o,
   output logic [NUM_BANKS-1:0]            bank_full_o,
   output logic                            bank_done_o,
   output logic [BANK_IDX_W-1:0]           done_bank_o,
   output logic [COUNT_WIDTH-1:0]          global_counts,
   output logic                            overflow_o
);

   wr_state_t               state;
   wr_state_t               state_n;
   logic [BANK_IDX_W-1:0]   bank_idx;
   logic [BANK_IDX_W-1:0]   next_idx;
   logic [BANK_IDX_W-1:0]   query_idx;
   logic [BANK_AW-1:0]      offset;
   logic [BANK_AW:0]        fill_len_q;
   logic [BANK_AW:0]        fill_len_eff;
   logic                    accept;
   logic                    last_word;
   logic                    complete;
   logic                    next_free;

   assign fill_len_eff = ((fill_len_i == '0) || (fill_len_i > (BANK_AW + 1)'(BANK_DEPTH)))
                         ? (BANK_AW + 1)'(BANK_DEPTH) : fill_len_i;

   assign next_idx  = (NUM_BANKS == 1) ? '0 : bank_idx + BANK_IDX_W'(1);
   assign accept    = (state == FILL) && count_up && !start_i;
   assign last_word = ({1'b0, offset} == (fill_len_q - (BANK_AW + 1)'(1)));
   assign complete  = accept && last_word;
   // While stalled, bank_idx already names the bank we are waiting for.
   assign query_idx = (state == WAIT_BANK) ? bank_idx : next_idx;
   assign ready_o   = (state == FILL);

   buffer_bank_status #(
      .NUM_BANKS (NUM_BANKS),
      .IDX_W     (BANK_IDX_W)
   ) u_status (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear_all  (start_i),
      .set_en     (complete),
      .set_idx    (bank_idx),
      .clr_en     (release_i && !start_i),
      .clr_idx    (release_bank_i),
      .query_idx  (query_idx),
      .bank_full  (bank_full_o),
      .query_free (next_free)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
         end
         FILL: begin
            if (complete && !next_free) begin
               state_n = WAIT_BANK;
            end
         end
         WAIT_BANK: begin
            if (next_free) begin
               state_n = FILL;
            end
         end
         default: state_n = IDLE;
      endcase
      if (start_i) begin
         state_n = FILL;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_idx      <= '0;
         offset        <= '0;
         fill_len_q    <= '0;
         global_counts <= '0;
         overflow_o    <= 1'b0;
         bank_done_o   <= 1'b0;
         done_bank_o   <= '0;
      end else begin
         bank_done_o <= complete;
         if (start_i) begin
            bank_idx      <= '0;
            offset        <= '0;
            fill_len_q    <= fill_len_eff;
            global_counts <= '0;
            overflow_o    <= 1'b0;
         end else begin
            if (accept) begin
               global_counts <= global_counts + COUNT_WIDTH'(1);
               if (last_word) begin
                  bank_idx    <= next_idx;
                  offset      <= '0;
                  done_bank_o <= bank_idx;
               end else begin
                  offset <= offset + BANK_AW'(1);
               end
            end
            if ((state == WAIT_BANK) && count_up) begin
               overflow_o <= 1'b1;
            end
         end
      end
   end

   if (NUM_BANKS == 1) begin : g_one_bank
      assign address = offset;
   end else begin : g_multi_bank
      assign address = {bank_idx, offset};
   end

endmodule
